victim_cache_lru: RTL

VICTIM_CACHE_LRU -- requirements
Module: victim_cache_lru

---
 rtl/victim_cache_lru_if.sv | 33 +++
 rtl/victim_cache_lru.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/victim_cache_lru_if.sv
// Victim cache bus: insert/lookup requests in, lookup results and evictions out.
interface victim_cache_lru_if #(
    parameter int unsigned BLOCK_WIDTH = 512,
    parameter int unsigned TAG_WIDTH   = 26
);
    logic [TAG_WIDTH-1:0]   WRITE_TAG_ADDRESS;
    logic [BLOCK_WIDTH-1:0] WRITE_DATA;
    logic                   WRITE_ENABLE;
    logic [TAG_WIDTH-1:0]   READ_TAG_ADDRESS;
    logic                   READ_ENBLE;
    logic                   READ_VALID;
    logic                   READ_HIT;
    logic [BLOCK_WIDTH-1:0] READ_DATA;
    logic                   EVICT_VALID;
    logic [TAG_WIDTH-1:0]   EVICT_TAG;
    logic [BLOCK_WIDTH-1:0] EVICT_DATA;

    // Cache side: consumes requests, produces results.
    modport slave (
        input  WRITE_TAG_ADDRESS, WRITE_DATA, WRITE_ENABLE,
        input  READ_TAG_ADDRESS, READ_ENBLE,
        output READ_VALID, READ_HIT, READ_DATA,
        output EVICT_VALID, EVICT_TAG, EVICT_DATA
    );

    // Requester side: L1 controller or testbench.
    modport master (
        output WRITE_TAG_ADDRESS, WRITE_DATA, WRITE_ENABLE,
        output READ_TAG_ADDRESS, READ_ENBLE,
        input  READ_VALID, READ_HIT, READ_DATA,
        input  EVICT_VALID, EVICT_TAG, EVICT_DATA
    );
endinterface

// File: rtl/victim_cache_lru.sv
// Fully-associative victim cache with true-LRU age counters.
// Reads are pipelined (1 or 2 cycles); writes allocate lowest invalid entry,
// else the LRU entry, reporting the displaced block one cycle later.
module victim_cache_lru #(
    parameter int unsigned BLOCK_WIDTH  = 512,
    parameter int unsigned TAG_WIDTH    = 26,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned SWAP_ON_HIT  = 1
) (
    input  logic                CLK,
    input  logic                RST,
    victim_cache_lru_if.slave   bus
);

    localparam int unsigned AGE_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef logic [AGE_W-1:0]            idx_t;
    typedef logic [DEPTH-1:0][AGE_W-1:0] age_vec_t;

    // Entry state
    logic [DEPTH-1:0]       valid_q, valid_d;
    age_vec_t               age_q, age_d;
    logic [TAG_WIDTH-1:0]   tag_q  [DEPTH];
    logic [BLOCK_WIDTH-1:0] data_q [DEPTH];

    // Lookup / allocation decode
    logic rd_hit_c, wr_hit_c, free_found_c;
    idx_t rd_idx_c, wr_idx_c, free_idx_c, lru_idx_c, lru2_idx_c, victim_idx_c, alloc_idx_c;
    logic rd_req_hit_c, rd_inval_c, evict_c;

    // Read pipeline and eviction registers
    logic                   rd1_valid_q, rd1_hit_q;
    logic [BLOCK_WIDTH-1:0] rd1_data_q;
    logic                   rd_out_valid, rd_out_hit;
    logic [BLOCK_WIDTH-1:0] rd_out_data;
    logic                   evict_valid_q;
    logic [TAG_WIDTH-1:0]   evict_tag_q;
    logic [BLOCK_WIDTH-1:0] evict_data_q;

    // Promote entry e to MRU; every younger entry ages by one.
    function automatic age_vec_t touch_age(input age_vec_t ages, input idx_t e);
        age_vec_t res;
        idx_t     e_age;
        res   = ages;
        e_age = ages[e];
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (ages[i] < e_age) begin
                res[i] = ages[i] + AGE_W'(1);
            end
        end
        res[e] = '0;
        return res;
    endfunction

    // Tag match for the read and write ports against pre-edge state.
    always_comb begin
        rd_hit_c = 1'b0;
        rd_idx_c = '0;
        wr_hit_c = 1'b0;
        wr_idx_c = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (valid_q[i] && (tag_q[i] == bus.READ_TAG_ADDRESS)) begin
                rd_hit_c = 1'b1;
                rd_idx_c = AGE_W'(i);
            end
            if (valid_q[i] && (tag_q[i] == bus.WRITE_TAG_ADDRESS)) begin
                wr_hit_c = 1'b1;
                wr_idx_c = AGE_W'(i);
            end
        end
    end

    // Free-slot search (lowest index) and oldest / second-oldest entries.
    always_comb begin
        free_found_c = 1'b0;
        free_idx_c   = '0;
        lru_idx_c    = '0;
        lru2_idx_c   = '0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_found_c = 1'b1;
                free_idx_c   = AGE_W'(i);
            end
        end
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (age_q[i] == AGE_W'(DEPTH - 1)) begin
                lru_idx_c = AGE_W'(i);
            end
            if (age_q[i] == AGE_W'(DEPTH - 2)) begin
                lru2_idx_c = AGE_W'(i);
            end
        end
    end

    // Choose the write target; an entry being swapped out by a read is skipped.
    always_comb begin
        rd_req_hit_c = bus.READ_ENBLE && rd_hit_c;
        rd_inval_c   = rd_req_hit_c && (SWAP_ON_HIT != 0);
        victim_idx_c = (rd_inval_c && (lru_idx_c == rd_idx_c)) ? lru2_idx_c : lru_idx_c;
        if (wr_hit_c) begin
            alloc_idx_c = wr_idx_c;
        end else if (free_found_c) begin
            alloc_idx_c = free_idx_c;
        end else begin
            alloc_idx_c = victim_idx_c;
        end
        evict_c = bus.WRITE_ENABLE && !wr_hit_c && !free_found_c;
    end

    // Next valid/age state: read effect first, then the write touch on top.
    always_comb begin
        valid_d = valid_q;
        age_d   = age_q;
        if (rd_req_hit_c) begin
            if (SWAP_ON_HIT != 0) begin
                valid_d[rd_idx_c] = 1'b0;
            end else begin
                age_d = touch_age(age_d, rd_idx_c);
            end
        end
        if (bus.WRITE_ENABLE) begin
            valid_d[alloc_idx_c] = 1'b1;
            age_d                = touch_age(age_d, alloc_idx_c);
        end
    end

    // Valid bits and ages; reset restores the identity age permutation.
    always_ff @(posedge CLK) begin
        if (RST) begin
            valid_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                age_q[i] <= AGE_W'(i);
            end
        end else begin
            valid_q <= valid_d;
            age_q   <= age_d;
        end
    end

    // Tag/data arrays are not reset; valid bits guard them.
    always_ff @(posedge CLK) begin
        if (!RST && bus.WRITE_ENABLE) begin
            tag_q[alloc_idx_c]  <= bus.WRITE_TAG_ADDRESS;
            data_q[alloc_idx_c] <= bus.WRITE_DATA;
        end
    end

    // Capture the displaced block before it is overwritten.
    always_ff @(posedge CLK) begin
        if (RST || !evict_c) begin
            evict_valid_q <= 1'b0;
            evict_tag_q   <= '0;
            evict_data_q  <= '0;
        end else begin
            evict_valid_q <= 1'b1;
            evict_tag_q   <= tag_q[alloc_idx_c];
            evict_data_q  <= data_q[alloc_idx_c];
        end
    end

    // First read stage: result from pre-edge contents, zeroed on a miss.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rd1_valid_q <= 1'b0;
            rd1_hit_q   <= 1'b0;
            rd1_data_q  <= '0;
        end else begin
            rd1_valid_q <= bus.READ_ENBLE;
            rd1_hit_q   <= rd_req_hit_c;
            rd1_data_q  <= rd_req_hit_c ? data_q[rd_idx_c] : '0;
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic                   rd2_valid_q, rd2_hit_q;
        logic [BLOCK_WIDTH-1:0] rd2_data_q;

        // Second read stage for the two-cycle configuration.
        always_ff @(posedge CLK) begin
            if (RST) begin
                rd2_valid_q <= 1'b0;
                rd2_hit_q   <= 1'b0;
                rd2_data_q  <= '0;
            end else begin
                rd2_valid_q <= rd1_valid_q;
                rd2_hit_q   <= rd1_hit_q;
                rd2_data_q  <= rd1_data_q;
            end
        end

        assign rd_out_valid = rd2_valid_q;
        assign rd_out_hit   = rd2_hit_q;
        assign rd_out_data  = rd2_data_q;
    end else begin : g_lat1
        assign rd_out_valid = rd1_valid_q;
        assign rd_out_hit   = rd1_hit_q;
        assign rd_out_data  = rd1_data_q;
    end

    assign bus.READ_VALID  = rd_out_valid;
    assign bus.READ_HIT    = rd_out_hit;
    assign bus.READ_DATA   = rd_out_data;
    assign bus.EVICT_VALID = evict_valid_q;
    assign bus.EVICT_TAG   = evict_tag_q;
    assign bus.EVICT_DATA  = evict_data_q;

endmodule
